nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that sits upstream of the 4-bit carry-skip slice (carry_skip_4bit).
//  It accepts WIDTH-bit operands over a valid/ready handshake and feeds them to one slice,
//  one nibble per clock, LSB first, with the slice's cout registered as the next nibble's cin.
//  It assembles the full sum, carry-out and signed overflow, and presents them over a valid/ready output.

---
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: a WIDTH-bit adder that is built from one 4-bit carry-skip slice.
// Operands arrive over a valid/ready handshake. The slice then processes one nibble per
// clock, LSB first, and the slice carry-out is registered as the carry-in of the next nibble.
// Handshake semantics: a transfer happens on a rising edge where valid && ready.
//   - Input side: in_ready is combinational. It is high in IDLE. In DONE it follows
//     out_ready, so a new operand set can be accepted on the same edge that consumes the
//     result. It is low in RUN and while rst_n is low.
//   - Output side: once out_valid is high, it and the result stay constant until an edge
//     with out_ready high.

// One 4-bit carry-skip slice. When all four bits propagate, the carry-in skips the ripple chain.
module carry_skip_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;

  assign w_p    = i_a ^ i_b;
  assign w_g    = i_a & i_b;
  assign w_c1   = w_g[0] | (w_p[0] & i_cin);
  assign w_c2   = w_g[1] | (w_p[1] & w_c1);
  assign w_c3   = w_g[2] | (w_p[2] & w_c2);
  assign w_c4   = w_g[3] | (w_p[3] & w_c3);
  assign o_sum  = w_p ^ {w_c3, w_c2, w_c1, i_cin};
  assign o_cout = (&w_p) ? i_cin : w_c4;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_res_next;

  carry_skip_4bit u_slice (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // The newest slice sum enters at the top, so after NIB passes nibble 0 sits at the bottom.
  assign w_res_next = {w_slice_sum, r_res[WIDTH-1:4]};
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_accept   = in_valid && w_in_ready;

  // Next-state and input-ready decode. in_ready is held low during reset.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_next = in_valid ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!rst_n) w_in_ready = 1'b0;
  end

  // State register, operand shifters, nibble counter and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DONE && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_res   <= '0;
        r_carry <= in_cin;
        r_a_msb <= in_a[WIDTH-1];
        r_b_msb <= in_b[WIDTH-1];
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= {4'b0000, r_a[WIDTH-1:4]};
        r_b     <= {4'b0000, r_b[WIDTH-1:4]};
        r_res   <= w_res_next;
        r_carry <= w_slice_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_out_sum   <= w_res_next;
          r_out_cout  <= w_slice_cout;
          r_out_ovf   <= (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign busy      = (r_state == S_RUN);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16). Directed cases plus randomized traffic.
// A driver pushes the expected responses when an operand set is accepted, and a monitor
// pops and compares them whenever a result is consumed.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [1:0]       dbg_state;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [WIDTH+1:0] exp_q[$];   // {sum, cout, ovf}
  int               acc_q[$];   // cycle stamp of each accept
  bit               rand_ready = 1'b0;
  logic             prev_v = 1'b0;

  // Reference model: the sum, carry and overflow are computed with plain wide arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {s[WIDTH-1:0], s[WIDTH], ovf};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Driver: presents one operand set and waits (bounded) for it to be accepted.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                      output int acc);
    bit done;
    done     = 1'b0;
    acc      = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, cin));
        acc = cyc + 1;
        acc_q.push_back(acc);
        done = 1'b1;
      end
    end
    if (!done) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks latency on each new result and compares each consumed result.
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && prev_v !== 1'b1) begin
        if (acc_q.size() == 0) fail_now("unexpected_valid");
        else check("latency", cyc - acc_q.pop_front(), NIB);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          e = exp_q.pop_front();
          check("sum",  {16'h0, out_sum}, {16'h0, e[WIDTH+1:2]});
          check("cout", {31'h0, out_cout}, {31'h0, e[1]});
          check("ovf",  {31'h0, out_ovf},  {31'h0, e[0]});
        end
      end
    end
    prev_v = out_valid;
  end

  // Random backpressure while enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_reset_outputs(input logic exp_in_ready);
    check("rst_in_ready",  {31'h0, in_ready},  {31'h0, exp_in_ready});
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_sum",   {16'h0, out_sum},   32'h0);
    check("rst_out_cout",  {31'h0, out_cout},  32'h0);
    check("rst_out_ovf",   {31'h0, out_ovf},   32'h0);
    check("rst_busy",      {31'h0, busy},      32'h0);
  endtask

  // Global time bound.
  initial begin
    #400000;
    fail_now("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Main stimulus sequence.
  initial begin
    int acc;
    int prev_acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Basic sum and 4-cycle latency.
    send(16'h1234, 16'h4321, 1'b0, acc);
    @(negedge clk);
    check("run_busy", {31'h0, busy}, 32'h1);
    check("run_in_ready", {31'h0, in_ready}, 32'h0);
    wait_drain();

    // Full-propagate chain, then the two signed-overflow cases.
    send(16'hFFFF, 16'h0000, 1'b1, acc);
    wait_drain();
    send(16'h7FFF, 16'h0001, 1'b0, acc);
    wait_drain();
    send(16'h8000, 16'h8000, 1'b0, acc);
    wait_drain();

    // Stall in DONE for 5 cycles while a new operand is offered and must be ignored.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, acc);
    for (int n = 0; n < 20 && out_valid !== 1'b1; n++) @(negedge clk);
    if (out_valid !== 1'b1) fail_now("stall_no_valid");
    in_a     = 16'hABCD;
    in_b     = 16'h1111;
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_valid",    {31'h0, out_valid}, 32'h1);
      check("stall_in_ready", {31'h0, in_ready},  32'h0);
      check("stall_sum",      {16'h0, out_sum},   32'h5555);
      check("stall_cout",     {31'h0, out_cout},  32'h0);
      check("stall_ovf",      {31'h0, out_ovf},   32'h0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back: one accept every NIB+1 cycles.
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), acc);
      if (i > 0) check("b2b_spacing", acc - prev_acc, NIB + 1);
      prev_acc = acc;
    end
    wait_drain();

    // Reset while RUN has cnt==2: the operation is discarded.
    send(16'h4444, 16'h3333, 1'b1, acc);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_reset_outputs(1'b1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("midrst_no_valid", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, acc);
    wait_drain();

    // Randomized traffic with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), acc);
    end
    @(posedge clk);
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    if (acc_q.size() != 0) fail_now("leftover_accepts");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
